// File: rtl/sycy_tea_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sycy_tea_pkg
// Description : Shared TEA constants, decryptor state encoding and the TEA
//               round function used by both half-round datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
package sycy_tea_pkg;

  localparam logic [31:0] TEA_DELTA    = 32'h9E3779B9;
  localparam int unsigned TEA_ROUNDS   = 32;
  localparam logic [31:0] TEA_SUM_INIT = 32'hC6EF3720;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALF1 = 2'd1,
    HALF2 = 2'd2,
    DONE  = 2'd3
  } dec_state_t;

  // F(x,a,b,s) = ((x<<4)+a) ^ (x+s) ^ ((x>>5)+b), all arithmetic mod 2^32.
  function automatic logic [31:0] tea_f(input logic [31:0] x,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] s);
    return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
  endfunction

  // Starting sum for decryption: DELTA added ROUNDS times, wrapped to 32 bits.
  function automatic logic [31:0] tea_sum_init(input logic [31:0] delta,
                                               input int unsigned rounds);
    return delta * rounds;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decryptor_half_round_1.sv
`default_nettype none
// ============================================================================
// Module      : decryptor_half_round_1
// Description : First TEA decryption half round: V1 - F(V0, k2, k3, sum).
// Ports       : v0_i, v1_i, sum_i (32b), key_i (64b = {k3,k2}), v1_o (32b)
// Revision    : 1.0 - initial release
// ============================================================================
module decryptor_half_round_1
  import sycy_tea_pkg::*;
(
  input  logic [31:0] v0_i,
  input  logic [31:0] v1_i,
  input  logic [31:0] sum_i,
  input  logic [63:0] key_i,
  output logic [31:0] v1_o
);

  assign v1_o = v1_i - tea_f(v0_i, key_i[31:0], key_i[63:32], sum_i);

endmodule
`default_nettype wire

// File: rtl/decryptor_half_round_2.sv
`default_nettype none
// ============================================================================
// Module      : decryptor_half_round_2
// Description : Second TEA decryption half round: V0 - F(V1, k0, k1, sum).
// Ports       : v0_i, v1_i, sum_i (32b), key_i (64b = {k1,k0}), v0_o (32b)
// Revision    : 1.0 - initial release
// ============================================================================
module decryptor_half_round_2
  import sycy_tea_pkg::*;
(
  input  logic [31:0] v0_i,
  input  logic [31:0] v1_i,
  input  logic [31:0] sum_i,
  input  logic [63:0] key_i,
  output logic [31:0] v0_o
);

  assign v0_o = v0_i - tea_f(v1_i, key_i[31:0], key_i[63:32], sum_i);

endmodule
`default_nettype wire

// File: rtl/tea_decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tea_decrypt_sequencer
// Description : Iterative TEA block decryptor. Accepts one 64-bit ciphertext
//               and 128-bit key, alternates the two half-round datapaths for
//               ROUNDS full rounds and presents the plaintext on a
//               valid/ready output. One block in flight at a time.
// Ports       : clk, rst (sync active-high)
//               in_valid/in_ready, in_data[63:0] {V1,V0}, in_key[127:0]
//               out_valid/out_ready, out_data[63:0] {V1,V0}
//               abort (only when SYCY_DEC_ABORT_EN is defined)
//               busy - high while rounds are executing
// Config      : SYCY_DEC_ABORT_EN - adds the abort input, which drops an
//               in-flight block and returns to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module tea_decrypt_sequencer
  import sycy_tea_pkg::*;
#(
  parameter int unsigned ROUNDS = TEA_ROUNDS,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic [127:0]  in_key,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef SYCY_DEC_ABORT_EN
  input  logic          abort,
`endif
  output logic [63:0]   out_data,
  output logic          busy
);

  localparam int          CW         = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] c_LAST   = CW'(ROUNDS - 1);
  localparam logic [31:0] c_SUM_INIT = tea_sum_init(DELTA, ROUNDS);

  dec_state_t     state_q, state_d;
  logic [31:0]    v0_q, v0_d;
  logic [31:0]    v1_q, v1_d;
  logic [31:0]    sum_q, sum_d;
  logic [127:0]   key_q, key_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [31:0]    w_v1_new;
  logic [31:0]    w_v0_new;
  logic           w_running;

  // Both datapaths see the live registers; only the one matching the
  // current half-round state gets written back.
  decryptor_half_round_1 u_half1 (
    .v0_i  (v0_q),
    .v1_i  (v1_q),
    .sum_i (sum_q),
    .key_i (key_q[127:64]),
    .v1_o  (w_v1_new)
  );

  decryptor_half_round_2 u_half2 (
    .v0_i  (v0_q),
    .v1_i  (v1_q),
    .sum_i (sum_q),
    .key_i (key_q[63:0]),
    .v0_o  (w_v0_new)
  );

  assign w_running = (state_q == HALF1) || (state_q == HALF2);

  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          v0_d    = in_data[31:0];
          v1_d    = in_data[63:32];
          key_d   = in_key;
          sum_d   = c_SUM_INIT;
          cnt_d   = '0;
          state_d = HALF1;
        end
      end
      HALF1: begin
        v1_d    = w_v1_new;
        state_d = HALF2;
      end
      HALF2: begin
        // Same sum is used by both halves of a round; step it afterwards.
        v0_d    = w_v0_new;
        sum_d   = sum_q - DELTA;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == c_LAST) ? DONE : HALF1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SYCY_DEC_ABORT_EN
    if (abort && w_running) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = w_running;
  // V0/V1 are frozen in DONE, so the plaintext is stable until taken.
  assign out_data  = {v1_q, v0_q};

  // Subtracting DELTA once per round must unwind the starting sum exactly.
  a_sum_unwound: assert property (@(posedge clk) disable iff (rst)
    (state_q == DONE) |-> (sum_q == 32'h0));

endmodule
`default_nettype wire

// File: tb/tb_tea_decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tea_decrypt_sequencer
// Description : Self-checking bench for tea_decrypt_sequencer. Random
//               plaintext/keys are encrypted by a C-style TEA model; the DUT
//               must recover the plaintext with the expected latency and
//               handshake behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tea_decrypt_sequencer;

  parameter int ROUNDS = 32;
  localparam logic [31:0] c_DELTA = 32'h9E3779B9;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic [127:0]  in_key;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          busy;
`ifdef SYCY_DEC_ABORT_EN
  logic          abort;
`endif

  int n_vec = 0;
  int n_err = 0;

  tea_decrypt_sequencer #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SYCY_DEC_ABORT_EN
    .abort     (abort),
`endif
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference TEA, written the way the C reference code is.
  function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k, input int rounds);
    logic [31:0] y, z, sum;
    y = p[31:0]; z = p[63:32]; sum = 32'h0;
    for (int i = 0; i < rounds; i++) begin
      sum = sum + c_DELTA;
      y = y + (((z << 4) + k[31:0]) ^ (z + sum) ^ ((z >> 5) + k[63:32]));
      z = z + (((y << 4) + k[95:64]) ^ (y + sum) ^ ((y >> 5) + k[127:96]));
    end
    return {z, y};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] c, input logic [127:0] k, input int rounds);
    logic [31:0] y, z, sum;
    y = c[31:0]; z = c[63:32]; sum = 32'h0;
    for (int i = 0; i < rounds; i++) sum = sum + c_DELTA;
    for (int i = 0; i < rounds; i++) begin
      z = z - (((y << 4) + k[95:64]) ^ (y + sum) ^ ((y >> 5) + k[127:96]));
      y = y - (((z << 4) + k[31:0]) ^ (z + sum) ^ ((z >> 5) + k[63:32]));
      sum = sum - c_DELTA;
    end
    return {z, y};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one block, wait for the result, optionally stall the sink.
  task automatic run_block(input logic [63:0] ct, input logic [127:0] key,
                           input logic [63:0] exp_pt, input int stall, input bit garbage);
    int   w, lat;
    bit   busy_ok, rdy_ok, hold_ok;
    logic [63:0] held;
    w = 0;
    while (!in_ready && w < 200) begin tick; w++; end
    check_eq("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = ct; in_key = key;
    tick;
    in_valid = 1'b0;
    lat = 1; busy_ok = 1'b1; rdy_ok = 1'b1;
    while (!out_valid && lat < 4 * ROUNDS + 10) begin
      if (!busy) busy_ok = 1'b0;
      if (in_ready) rdy_ok = 1'b0;
      if (garbage) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        in_data   = {$urandom, $urandom};
        in_key    = {$urandom, $urandom, $urandom, $urandom};
      end
      tick;
      lat++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("latency", 64'(lat), 64'(2 * ROUNDS + 1));
    check_eq("busy_running", 64'(busy_ok), 64'd1);
    check_eq("in_ready_low_running", 64'(rdy_ok), 64'd1);
    check_eq("plaintext", out_data, exp_pt);
    held = out_data; hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick;
      if (!out_valid || out_data !== held || in_ready || busy) hold_ok = 1'b0;
    end
    if (stall > 0) check_eq("stall_hold", 64'(hold_ok), 64'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_eq("out_valid_drop", 64'(out_valid), 64'd0);
    check_eq("in_ready_after_done", 64'(in_ready), 64'd1);
  endtask

  // Start a block and return in cycle T+n (n >= 1).
  task automatic start_and_wait(input int n);
    in_valid = 1'b1; in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom, $urandom, $urandom};
    tick;
    in_valid = 1'b0;
    for (int i = 1; i < n; i++) tick;
  endtask

  task automatic expect_quiet(input string tag);
    bit quiet;
    quiet = 1'b1;
    for (int i = 0; i < 2 * ROUNDS + 8; i++) begin
      tick;
      if (out_valid || busy) quiet = 1'b0;
    end
    check_eq(tag, 64'(quiet), 64'd1);
  endtask

  initial begin
    logic [63:0]  pt, ct;
    logic [127:0] key;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
`ifdef SYCY_DEC_ABORT_EN
    abort = 1'b0;
`endif
    tick; tick;
    rst = 1'b0;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);

    // Known vector: all-zero key, ciphertext of the all-zero block.
    ct = 64'h94BAA940_41EA3A0A;
    run_block(ct, 128'h0, tea_dec(ct, 128'h0, ROUNDS), 0, 1'b0);

    // Back-to-back random blocks with a stalled sink.
    for (int b = 0; b < 4; b++) begin
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      run_block(tea_enc(pt, key, ROUNDS), key, pt, 10, 1'b0);
    end

    // Garbage on the input side while a block is running.
    for (int b = 0; b < 4; b++) begin
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      run_block(tea_enc(pt, key, ROUNDS), key, pt, $urandom_range(0, 3), 1'b1);
    end

    // Reset mid-block discards it.
    start_and_wait(20);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    expect_quiet("midrst_no_result");
    pt  = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    run_block(tea_enc(pt, key, ROUNDS), key, pt, 2, 1'b0);

`ifdef SYCY_DEC_ABORT_EN
    start_and_wait(30);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_eq("abort_in_ready", 64'(in_ready), 64'd1);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_out_valid", 64'(out_valid), 64'd0);
    expect_quiet("abort_no_result");
    pt  = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    run_block(tea_enc(pt, key, ROUNDS), key, pt, 1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
